// File: rtl/mema_row_writer.sv
// Reassembles per-lane element chunks into one packed A-matrix row word and
// commits complete rows to an internal memory with a combinational read port.
module mema_row_writer #(
  parameter int no_of_elements_on_col_nos   = 20,
  parameter int no_of_row_by_vector_modules = 4,
  parameter int element_width               = 32,
  parameter int no_of_units                 = 8,
  parameter int mem_depth                   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             write_base_address,
  input  logic [15:0]             num_rows,
  input  logic [no_of_row_by_vector_modules*no_of_units*element_width-1:0] chunk_in,
  input  logic [no_of_row_by_vector_modules-1:0] chunk_valid,
  output logic [no_of_row_by_vector_modules-1:0] chunk_ready,
  output logic                    busy,
  output logic                    row_done,
  output logic [31:0]             write_address_out,
  input  logic [31:0]             mem_read_address,
  output logic [no_of_row_by_vector_modules*no_of_elements_on_col_nos*element_width-1:0] mem_read_data
);

  // state   | meaning
  // IDLE    | waiting for start with a nonzero row count
  // COLLECT | accepting chunks until every lane has delivered all of its chunks
  // COMMIT  | one cycle; the closing edge writes the assembled row to memory

  localparam int N       = no_of_elements_on_col_nos;
  localparam int R       = no_of_row_by_vector_modules;
  localparam int E       = element_width;
  localparam int U       = no_of_units;
  localparam int M       = (N + U - 1) / U;
  localparam int OV      = N % U;
  localparam int OV_W    = (OV == 0) ? U : OV;
  localparam int ROW_W   = R * N * E;
  localparam int CHUNK_W = U * E;
  localparam int CW      = $clog2(M + 2);
  localparam int AW      = (mem_depth > 1) ? $clog2(mem_depth) : 1;

  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(M);
  localparam logic [CW-1:0]        CNT_DONE = CW'(M + 1);
  localparam logic [R-1:0][CW-1:0] CNT_INIT = {R{CNT_ONE}};
  localparam logic [31:0]          MEM_LIM  = 32'(mem_depth);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } state_t;

  state_t                state_q, state_d;
  logic [R-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [ROW_W-1:0]      buf_q, buf_d;
  logic [31:0]           addr_q, addr_d;
  logic [15:0]           rows_q, rows_d;
  logic [31:0]           wr_addr_q, wr_addr_d;
  logic                  row_done_q, row_done_d;
  logic                  mem_we;
  logic                  all_done;
  int                    k;
  int                    base;

  logic [ROW_W-1:0]      mem_q [mem_depth];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    addr_d      = addr_q;
    rows_d      = rows_q;
    wr_addr_d   = wr_addr_q;
    row_done_d  = 1'b0;
    mem_we      = 1'b0;
    chunk_ready = '0;
    all_done    = 1'b1;
    k           = 0;
    base        = 0;

    case (state_q)
      IDLE: begin
        if (start && (num_rows != 16'd0)) begin
          state_d = COLLECT;
          cnt_d   = CNT_INIT;
          buf_d   = '0;
          addr_d  = write_base_address;
          rows_d  = num_rows;
        end
      end

      COLLECT: begin
        for (int i = 0; i < R; i++) begin
          k    = int'(cnt_q[i]);
          base = ((i + 1) * N - (k - 1) * U) * E - 1;
          chunk_ready[i] = (cnt_q[i] <= CNT_LAST);
          if (chunk_ready[i] && chunk_valid[i]) begin
            // the final chunk of a lane only carries OV live elements in its top slots
            if ((OV != 0) && (k == M)) begin
              buf_d[base -: OV_W*E] = chunk_in[(i+1)*CHUNK_W-1 -: OV_W*E];
            end else begin
              buf_d[base -: CHUNK_W] = chunk_in[(i+1)*CHUNK_W-1 -: CHUNK_W];
            end
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
          if (cnt_d[i] != CNT_DONE) begin
            all_done = 1'b0;
          end
        end
        if (all_done) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        mem_we     = (addr_q < MEM_LIM);
        wr_addr_d  = addr_q;
        row_done_d = 1'b1;
        addr_d     = addr_q + 32'd1;
        rows_d     = rows_q - 16'd1;
        cnt_d      = CNT_INIT;
        buf_d      = '0;
        state_d    = (rows_q != 16'd1) ? COLLECT : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_INIT;
      buf_q      <= '0;
      addr_q     <= '0;
      rows_q     <= '0;
      wr_addr_q  <= '0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      rows_q     <= rows_d;
      wr_addr_q  <= wr_addr_d;
      row_done_q <= row_done_d;
    end
  end

  // memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[addr_q[AW-1:0]] <= buf_q;
    end
  end

  assign mem_read_data     = (mem_read_address < MEM_LIM) ? mem_q[mem_read_address[AW-1:0]] : '0;
  assign busy              = (state_q != IDLE);
  assign row_done          = row_done_q;
  assign write_address_out = wr_addr_q;

endmodule

// File: tb/tb_mema_row_writer.sv
// Directed bench for mema_row_writer: streams lane chunks and checks timing,
// row packing, overflow discard, address wrap/drop, reset abort and start filtering.
module tb_mema_row_writer;

  localparam int N     = 20;
  localparam int R     = 4;
  localparam int E     = 32;
  localparam int U     = 8;
  localparam int M     = 3;
  localparam int ROW_W = R * N * E;
  localparam int CH_W  = U * E;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       write_base_address;
  logic [15:0]       num_rows;
  logic [R*CH_W-1:0] chunk_in;
  logic [R-1:0]      chunk_valid;
  logic [R-1:0]      chunk_ready;
  logic              busy;
  logic              row_done;
  logic [31:0]       write_address_out;
  logic [31:0]       mem_read_address;
  logic [ROW_W-1:0]  mem_read_data;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int rd_count = 0;
  int rd_t[$];
  int lane_delay[R];
  int last_xfer[R];
  int first_xfer;
  int ready_viol = 0;
  int c0;

  mema_row_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .write_base_address (write_base_address),
    .num_rows           (num_rows),
    .chunk_in           (chunk_in),
    .chunk_valid        (chunk_valid),
    .chunk_ready        (chunk_ready),
    .busy               (busy),
    .row_done           (row_done),
    .write_address_out  (write_address_out),
    .mem_read_address   (mem_read_address),
    .mem_read_data      (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (row_done === 1'b1) begin
      rd_count++;
      rd_t.push_back(cyc_cnt);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen(input int seed, input int l, input int i);
    return 32'(seed * 1000 + l * 100 + i);
  endfunction

  function automatic logic [CH_W-1:0] mk_chunk(input int seed, input int l, input int k,
                                              input logic [31:0] fill);
    logic [CH_W-1:0] c;
    int idx;
    c = '0;
    for (int j = 0; j < U; j++) begin
      idx = (k - 1) * U + j;
      c[(U-j)*E-1 -: E] = (idx < N) ? gen(seed, l, idx) : fill;
    end
    return c;
  endfunction

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    write_base_address = b;
    num_rows = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream_row(input int seed, input logic [31:0] fill, input bit mid_start);
    int nxt[R];
    int it;
    bit left;
    for (int i = 0; i < R; i++) nxt[i] = 1;
    it = 0;
    first_xfer = -1;
    left = 1'b1;
    while (left && it < 300) begin
      @(negedge clk);
      if (mid_start) begin
        start = (it == 1);
        if (it == 1) begin
          write_base_address = 32'd60;
          num_rows = 16'd5;
        end
      end
      for (int i = 0; i < R; i++) begin
        if (nxt[i] <= M && it >= lane_delay[i]) begin
          chunk_valid[i] = 1'b1;
          chunk_in[(i+1)*CH_W-1 -: CH_W] = mk_chunk(seed, i + 1, nxt[i], fill);
          if (chunk_ready[i]) begin
            if (first_xfer < 0) first_xfer = cyc_cnt;
            last_xfer[i] = cyc_cnt;
            nxt[i]++;
          end
        end else begin
          chunk_valid[i] = 1'b0;
          if (nxt[i] > M && chunk_ready[i]) ready_viol++;
        end
      end
      it++;
      left = 1'b0;
      for (int i = 0; i < R; i++) if (nxt[i] <= M) left = 1'b1;
    end
    if (left) check("stream_timeout", 64'(it), 64'd0);
  endtask

  task automatic end_stream();
    @(negedge clk);
    chunk_valid = '0;
    start = 1'b0;
  endtask

  task automatic read_row(input logic [31:0] a, output logic [ROW_W-1:0] row);
    mem_read_address = a;
    #1;
    row = mem_read_data;
  endtask

  task automatic check_row(input string tag, input logic [31:0] a, input int seed);
    logic [ROW_W-1:0] row;
    logic [31:0] v;
    int nbad;
    int nfill;
    nbad = 0;
    nfill = 0;
    read_row(a, row);
    for (int l = 1; l <= R; l++) begin
      for (int i = 0; i < N; i++) begin
        v = row[(l*N-i)*E-1 -: E];
        if (v !== gen(seed, l, i)) nbad++;
        if (v == 32'hDEADBEEF) nfill++;
      end
    end
    check({tag, "_elems_bad"}, 64'(nbad), 64'd0);
    check({tag, "_fill_seen"}, 64'(nfill), 64'd0);
  endtask

  initial begin
    logic [ROW_W-1:0] row;
    reset = 1'b1;
    start = 1'b0;
    write_base_address = '0;
    num_rows = '0;
    chunk_in = '0;
    chunk_valid = '0;
    mem_read_address = '0;
    for (int i = 0; i < R; i++) begin
      lane_delay[i] = 0;
      last_xfer[i] = 0;
    end

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(chunk_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_row_done", 64'(row_done), 64'd0);
    check("rst_waddr", 64'(write_address_out), 64'd0);
    reset = 1'b0;
    read_row(32'd2000, row);
    check("oob_read_2000", 64'(|row), 64'd0);

    // basic row, lanes back-to-back
    pulse_start(32'd5, 16'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready", 64'(chunk_ready), 64'hF);
    stream_row(0, 32'd0, 1'b0);
    end_stream();
    repeat (4) @(negedge clk);
    check("t1_rd_count", 64'(rd_count), 64'd1);
    check("t1_latency", 64'(rd_t[rd_t.size()-1] - first_xfer), 64'd4);
    check("t1_waddr", 64'(write_address_out), 64'd5);
    check("t1_busy_end", 64'(busy), 64'd0);
    check_row("t1_mem5", 32'd5, 0);

    // overflow slots in last chunk carry DEADBEEF and must be discarded
    pulse_start(32'd8, 16'd1);
    stream_row(2, 32'hDEADBEEF, 1'b0);
    end_stream();
    repeat (4) @(negedge clk);
    check_row("t2_mem8", 32'd8, 2);
    read_row(32'd8, row);
    check("t2_lane4_elem16", 64'(row[(4*N-16)*E-1 -: E]), 64'(gen(2, 4, 16)));

    // lane 1 lags the others by 10 cycles
    lane_delay[0] = 10;
    c0 = rd_count;
    ready_viol = 0;
    pulse_start(32'd9, 16'd1);
    stream_row(3, 32'hDEADBEEF, 1'b0);
    end_stream();
    repeat (4) @(negedge clk);
    lane_delay[0] = 0;
    check("t3_rd_count", 64'(rd_count - c0), 64'd1);
    check("t3_latency", 64'(rd_t[rd_t.size()-1] - last_xfer[0]), 64'd2);
    check("t3_skew", 64'(last_xfer[0] - last_xfer[1]), 64'd10);
    check("t3_ready_viol", 64'(ready_viol), 64'd0);
    check_row("t3_mem9", 32'd9, 3);

    // address wrap: 0xFFFFFFFF dropped, then rows land at 0 and 1
    pulse_start(32'd1023, 16'd1);
    stream_row(7, 32'd0, 1'b0);
    end_stream();
    repeat (4) @(negedge clk);
    c0 = rd_count;
    pulse_start(32'hFFFF_FFFF, 16'd3);
    stream_row(4, 32'd0, 1'b0);
    stream_row(5, 32'd0, 1'b0);
    stream_row(6, 32'd0, 1'b0);
    end_stream();
    repeat (4) @(negedge clk);
    check("t4_rd_count", 64'(rd_count - c0), 64'd3);
    check("t4_row_period", 64'(rd_t[rd_t.size()-1] - rd_t[rd_t.size()-2]), 64'd4);
    check("t4_waddr", 64'(write_address_out), 64'd1);
    check("t4_busy_end", 64'(busy), 64'd0);
    check_row("t4_mem0", 32'd0, 5);
    check_row("t4_mem1", 32'd1, 6);
    check_row("t4_mem1023", 32'd1023, 7);
    read_row(32'hFFFF_FFFF, row);
    check("t4_oob_read_max", 64'(|row), 64'd0);

    // reset after two chunks of lane 3 aborts the row
    pulse_start(32'd20, 16'd1);
    c0 = rd_count;
    chunk_valid[2] = 1'b1;
    chunk_in[3*CH_W-1 -: CH_W] = mk_chunk(9, 3, 1, 32'd0);
    @(negedge clk);
    chunk_in[3*CH_W-1 -: CH_W] = mk_chunk(9, 3, 2, 32'd0);
    @(negedge clk);
    chunk_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", 64'(chunk_ready), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    pulse_start(32'd20, 16'd1);
    stream_row(10, 32'd0, 1'b0);
    end_stream();
    repeat (4) @(negedge clk);
    check("t5_rd_count", 64'(rd_count - c0), 64'd1);
    check_row("t5_mem20", 32'd20, 10);

    // start with zero rows, then a start pulse during COLLECT
    c0 = rd_count;
    pulse_start(32'd50, 16'd0);
    check("t6_zero_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("t6_zero_rd", 64'(rd_count - c0), 64'd0);
    pulse_start(32'd40, 16'd1);
    stream_row(11, 32'd0, 1'b1);
    end_stream();
    repeat (4) @(negedge clk);
    check("t6_rd_count", 64'(rd_count - c0), 64'd1);
    check("t6_waddr", 64'(write_address_out), 64'd40);
    check("t6_busy_end", 64'(busy), 64'd0);
    check_row("t6_mem40", 32'd40, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
